// File: rtl/muldiv_hilo_ctrl_pkg.sv
// Shared constants, funct codes, state/mode encodings and sign helpers for the
// multiply/divide sequencer and its HI/LO register pair.
package muldiv_hilo_ctrl_pkg;

    localparam int W        = 32;
    localparam int W_CNT    = 6;
    localparam int W_OPCODE = 6;

    localparam logic [W_OPCODE-1:0] F_MFHI  = 6'h10;
    localparam logic [W_OPCODE-1:0] F_MTHI  = 6'h11;
    localparam logic [W_OPCODE-1:0] F_MFLO  = 6'h12;
    localparam logic [W_OPCODE-1:0] F_MTLO  = 6'h13;
    localparam logic [W_OPCODE-1:0] F_MULT  = 6'h18;
    localparam logic [W_OPCODE-1:0] F_MULTU = 6'h19;
    localparam logic [W_OPCODE-1:0] F_DIV   = 6'h1A;
    localparam logic [W_OPCODE-1:0] F_DIVU  = 6'h1B;

    localparam logic [W_CNT-1:0] CNT_INIT = W_CNT'(W);
    localparam logic [W_CNT-1:0] CNT_ONE  = 6'd1;
    localparam logic [W_CNT-1:0] CNT_ZERO = 6'd0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MUL   = 2'd1,
        S_DIV   = 2'd2,
        S_FIXUP = 2'd3
    } state_e;

    typedef enum logic {
        MD_MUL = 1'b0,
        MD_DIV = 1'b1
    } md_mode_e;

    function automatic logic [W-1:0] neg_w(input logic [W-1:0] v, input logic n);
        return n ? (~v + {{(W-1){1'b0}}, 1'b1}) : v;
    endfunction

    function automatic logic [W-1:0] abs_w(input logic [W-1:0] v);
        return neg_w(v, v[W-1]);
    endfunction

endpackage

// File: rtl/muldiv_hilo_ctrl_if.sv
// CPU-facing request/response bundle of the multiply/divide unit.
interface muldiv_hilo_ctrl_if;
    import muldiv_hilo_ctrl_pkg::*;

    logic                start;
    logic [W_OPCODE-1:0] funct;
    logic [W-1:0]        A;
    logic [W-1:0]        B;
    logic                busy;
    logic                done;
    logic                div_by_zero;
    logic [W-1:0]        hi;
    logic [W-1:0]        lo;

    modport master (output start, funct, A, B, input busy, done, div_by_zero, hi, lo);
    modport slave  (input start, funct, A, B, output busy, done, div_by_zero, hi, lo);
endinterface

// File: rtl/muldiv_hilo_ctrl_step.sv
// One combinational iteration: shift-add multiply step or restoring divide step.
// In divide mode the divisor sits in mcand_i[W-1:0] and acc holds {remainder, dividend/quotient}.
module muldiv_hilo_ctrl_step
    import muldiv_hilo_ctrl_pkg::*;
(
    input  md_mode_e       mode,
    input  logic [2*W-1:0] acc_i,
    input  logic [W-1:0]   opnd_i,
    input  logic [2*W-1:0] mcand_i,
    output logic [2*W-1:0] acc_o,
    output logic [W-1:0]   opnd_o,
    output logic [2*W-1:0] mcand_o
);
    logic [2*W:0] sh_s;
    logic [W:0]   diff_s;

    // Single multiply or divide iteration
    always_comb begin
        sh_s    = {acc_i, 1'b0};
        diff_s  = sh_s[2*W:W] - {1'b0, mcand_i[W-1:0]};
        acc_o   = acc_i;
        opnd_o  = opnd_i;
        mcand_o = mcand_i;
        case (mode)
            MD_MUL: begin
                if (opnd_i[0]) begin
                    acc_o = acc_i + mcand_i;
                end else begin
                    acc_o = acc_i;
                end
                opnd_o  = {1'b0, opnd_i[W-1:1]};
                mcand_o = {mcand_i[2*W-2:0], 1'b0};
            end
            MD_DIV: begin
                if (!diff_s[W]) begin
                    acc_o = {diff_s[W-1:0], sh_s[W-1:1], 1'b1};
                end else begin
                    acc_o = sh_s[2*W-1:0];
                end
            end
            default: begin
                acc_o = acc_i;
            end
        endcase
    end
endmodule

// File: rtl/muldiv_hilo_ctrl.sv
// MULT/MULTU/DIV/DIVU sequencer and HI/LO owner. Define MULDIV_EARLY_OUT_EN to let
// multiplies finish as soon as the remaining multiplier bits are zero.
module muldiv_hilo_ctrl
    import muldiv_hilo_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    muldiv_hilo_ctrl_if.slave bus
);
    state_e           state_q, state_d;
    logic [W_CNT-1:0] cnt_q, cnt_d;
    logic [2*W-1:0]   acc_q, acc_d, mcand_q, mcand_d;
    logic [W-1:0]     opnd_q, opnd_d, hi_q, hi_d, lo_q, lo_d;
    logic             is_div_q, is_div_d, dbz_q, dbz_d;
    logic             neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
    logic             busy_q, busy_d, done_q, done_d, dbz_out_q, dbz_out_d;

    md_mode_e         step_mode_s;
    logic [2*W-1:0]   step_acc_s, step_mcand_s, prod_s;
    logic [W-1:0]     step_opnd_s, a_mag_s, b_mag_s, quo_s, rem_s, dbz_hi_s;
    logic             sgn_s, early_s;

    assign step_mode_s = (state_q == S_DIV) ? MD_DIV : MD_MUL;

    muldiv_hilo_ctrl_step u_step (
        .mode    (step_mode_s),
        .acc_i   (acc_q),
        .opnd_i  (opnd_q),
        .mcand_i (mcand_q),
        .acc_o   (step_acc_s),
        .opnd_o  (step_opnd_s),
        .mcand_o (step_mcand_s)
    );

`ifdef MULDIV_EARLY_OUT_EN
    assign early_s = (step_opnd_s == {W{1'b0}});
`else
    assign early_s = 1'b0;
`endif

    // Operand magnitudes and sign-corrected results
    always_comb begin
        sgn_s    = (bus.funct == F_MULT) || (bus.funct == F_DIV);
        a_mag_s  = sgn_s ? abs_w(bus.A) : bus.A;
        b_mag_s  = sgn_s ? abs_w(bus.B) : bus.B;
        prod_s   = neg_res_q ? (~acc_q + {{(2*W-1){1'b0}}, 1'b1}) : acc_q;
        quo_s    = neg_w(acc_q[W-1:0], neg_res_q);
        rem_s    = neg_w(acc_q[2*W-1:W], neg_rem_q);
        dbz_hi_s = neg_w(acc_q[W-1:0], neg_rem_q);
    end

    // Next-state, datapath and output logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        mcand_d   = mcand_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        is_div_d  = is_div_q;
        dbz_d     = dbz_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        done_d    = 1'b0;
        dbz_out_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    case (bus.funct)
                        F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                            is_div_d  = (bus.funct == F_DIV) || (bus.funct == F_DIVU);
                            neg_res_d = sgn_s & (bus.A[W-1] ^ bus.B[W-1]);
                            neg_rem_d = sgn_s & bus.A[W-1];
                            cnt_d     = CNT_INIT;
                            if (is_div_d) begin
                                acc_d   = {{W{1'b0}}, a_mag_s};
                                mcand_d = {{W{1'b0}}, b_mag_s};
                                opnd_d  = {W{1'b0}};
                                dbz_d   = (bus.B == {W{1'b0}});
                                state_d = S_DIV;
                            end else begin
                                acc_d   = {(2*W){1'b0}};
                                mcand_d = {{W{1'b0}}, a_mag_s};
                                opnd_d  = b_mag_s;
                                dbz_d   = 1'b0;
                                state_d = S_MUL;
                            end
                        end
                        F_MTHI:  hi_d = bus.A;
                        F_MTLO:  lo_d = bus.A;
                        default: state_d = S_IDLE;
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MUL: begin
                acc_d   = step_acc_s;
                opnd_d  = step_opnd_s;
                mcand_d = step_mcand_s;
                cnt_d   = cnt_q - CNT_ONE;
                if ((cnt_q == CNT_ONE) || early_s) begin
                    state_d = S_FIXUP;
                end else begin
                    state_d = S_MUL;
                end
            end
            S_DIV: begin
                // A zero divisor keeps the dividend magnitude untouched for the HI result
                if (!dbz_q) begin
                    acc_d = step_acc_s;
                end else begin
                    acc_d = acc_q;
                end
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = S_FIXUP;
                end else begin
                    state_d = S_DIV;
                end
            end
            S_FIXUP: begin
                state_d   = S_IDLE;
                cnt_d     = CNT_ZERO;
                done_d    = 1'b1;
                dbz_out_d = dbz_q;
                if (!is_div_q) begin
                    hi_d = prod_s[2*W-1:W];
                    lo_d = prod_s[W-1:0];
                end else if (dbz_q) begin
                    hi_d = dbz_hi_s;
                    lo_d = {W{1'b1}};
                end else begin
                    hi_d = rem_s;
                    lo_d = quo_s;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= CNT_ZERO;
            acc_q     <= {(2*W){1'b0}};
            opnd_q    <= {W{1'b0}};
            mcand_q   <= {(2*W){1'b0}};
            hi_q      <= {W{1'b0}};
            lo_q      <= {W{1'b0}};
            is_div_q  <= 1'b0;
            dbz_q     <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            mcand_q   <= mcand_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            is_div_q  <= is_div_d;
            dbz_q     <= dbz_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dbz_out_q <= dbz_out_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_out_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Directed and random bench for muldiv_hilo_ctrl; expected HI/LO/latency come from a
// native-arithmetic model queued at issue time and checked when done pulses.
module tb_muldiv_hilo_ctrl;
    import muldiv_hilo_ctrl_pkg::*;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          lat;
        int          t0;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;
    int   fails = 0;
    int   busy_acc = 0;
    exp_t sb[$];

    muldiv_hilo_ctrl_if bus_if ();

    muldiv_hilo_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic int bitlen(input logic [31:0] v);
        int n = 0;
        for (int i = 0; i < 32; i++) if (v[i]) n = i + 1;
        return n;
    endfunction

    function automatic exp_t model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      sa, sbv, q, r;
        logic [63:0] p;
        logic [31:0] mb;
        e.dbz = 1'b0;
        e.lat = 34;
        e.t0  = 0;
        sa    = longint'($signed(a));
        sbv   = longint'($signed(b));
        mb    = b;
        if (f == F_MULT) begin
            p    = 64'(sa * sbv);
            e.hi = p[63:32];
            e.lo = p[31:0];
            mb   = b[31] ? (32'd0 - b) : b;
        end else if (f == F_MULTU) begin
            p    = {32'd0, a} * {32'd0, b};
            e.hi = p[63:32];
            e.lo = p[31:0];
        end else if (b == 32'd0) begin
            e.hi  = a;
            e.lo  = 32'hFFFF_FFFF;
            e.dbz = 1'b1;
        end else if (f == F_DIV) begin
            q    = sa / sbv;
            r    = sa % sbv;
            p    = 64'(q);
            e.lo = p[31:0];
            p    = 64'(r);
            e.hi = p[31:0];
        end else begin
            e.lo = a / b;
            e.hi = a % b;
        end
`ifdef MULDIV_EARLY_OUT_EN
        if (f == F_MULT || f == F_MULTU) e.lat = ((bitlen(mb) < 1) ? 1 : bitlen(mb)) + 2;
`else
        if (bitlen(mb) > 32) e.lat = 0;
`endif
        return e;
    endfunction

    task automatic tick();
        if (bus_if.busy) busy_acc++;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e = model(f, a, b);
        bus_if.start = 1'b1;
        bus_if.funct = f;
        bus_if.A     = a;
        bus_if.B     = b;
        @(posedge clk);
        #1;
        bus_if.start = 1'b0;
        e.t0     = cyc;
        busy_acc = 0;
        sb.push_back(e);
    endtask

    task automatic wait_done(input string tag);
        exp_t e;
        int   k = 0;
        while (!bus_if.done && k < 200) begin
            tick();
            k++;
        end
        if (!bus_if.done) begin
            chk({tag, " timeout"}, 64'(bus_if.done), 64'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, " hi"}, 64'(bus_if.hi), 64'(e.hi));
            chk({tag, " lo"}, 64'(bus_if.lo), 64'(e.lo));
            chk({tag, " dbz"}, 64'(bus_if.div_by_zero), 64'(e.dbz));
            chk({tag, " latency"}, 64'(cyc - e.t0 + 1), 64'(e.lat));
            chk({tag, " busy cycles"}, 64'(busy_acc), 64'(e.lat - 1));
            chk({tag, " busy at done"}, 64'(bus_if.busy), 64'd0);
            tick();
            chk({tag, " done width"}, 64'(bus_if.done), 64'd0);
        end
    endtask

    initial begin
        logic [31:0] lo_before;
        logic [5:0]  fn;
        logic [31:0] ra, rb;
        rst_n        = 1'b0;
        bus_if.start = 1'b0;
        bus_if.funct = 6'd0;
        bus_if.A     = 32'd0;
        bus_if.B     = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset hi", 64'(bus_if.hi), 64'd0);
        chk("reset lo", 64'(bus_if.lo), 64'd0);
        chk("reset busy", 64'(bus_if.busy), 64'd0);
        chk("reset done", 64'(bus_if.done), 64'd0);
        chk("reset dbz", 64'(bus_if.div_by_zero), 64'd0);
        rst_n = 1'b1;
        tick();

        issue(F_MULT, 32'hFFFF_FFFD, 32'd5);             wait_done("mult -3*5");
        issue(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);    wait_done("multu max");
        issue(F_DIV, 32'hFFFF_FFF9, 32'd2);              wait_done("div -7/2");
        issue(F_DIVU, 32'd100, 32'd0);                   wait_done("divu by 0");
        issue(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);      wait_done("div wrap");
        issue(F_DIV, 32'hFFFF_FFFB, 32'd0);              wait_done("div -5 by 0");
        issue(F_DIV, 32'd7, 32'hFFFF_FFFE);              wait_done("div 7/-2");
        issue(F_DIVU, 32'hFFFF_FFFF, 32'd7);             wait_done("divu max/7");
        issue(F_MULT, 32'h8000_0000, 32'h8000_0000);     wait_done("mult min*min");
        issue(F_MULTU, 32'd9, 32'd1);                    wait_done("multu 9*1");
        issue(F_MULTU, 32'd12345, 32'd0);                wait_done("multu by 0");

        // MTLO while a multiply is in flight must be dropped
        issue(F_MULT, 32'd3, 32'd4);
        repeat (4) tick();
        lo_before    = bus_if.lo;
        bus_if.start = 1'b1;
        bus_if.funct = F_MTLO;
        bus_if.A     = 32'h0000_1234;
        tick();
        bus_if.start = 1'b0;
        chk("mtlo busy lo", 64'(bus_if.lo), 64'(lo_before));
        wait_done("mult with mtlo");

        bus_if.start = 1'b1;
        bus_if.funct = F_MTHI;
        bus_if.A     = 32'd7;
        tick();
        bus_if.start = 1'b0;
        chk("mthi hi", 64'(bus_if.hi), 64'd7);
        chk("mthi lo kept", 64'(bus_if.lo), 64'd12);
        chk("mthi done", 64'(bus_if.done), 64'd0);
        chk("mthi busy", 64'(bus_if.busy), 64'd0);

        bus_if.start = 1'b1;
        bus_if.funct = F_MTLO;
        bus_if.A     = 32'hCAFE_F00D;
        tick();
        bus_if.start = 1'b0;
        chk("mtlo lo", 64'(bus_if.lo), 64'hCAFE_F00D);
        chk("mtlo hi kept", 64'(bus_if.hi), 64'd7);

        // Reset in the middle of a divide discards it
        issue(F_DIVU, 32'd1000, 32'd3);
        while (cyc < sb[0].t0 + 9) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        void'(sb.pop_back());
        chk("midrst hi", 64'(bus_if.hi), 64'd0);
        chk("midrst lo", 64'(bus_if.lo), 64'd0);
        chk("midrst busy", 64'(bus_if.busy), 64'd0);
        chk("midrst done", 64'(bus_if.done), 64'd0);
        for (int i = 0; i < 40; i++) begin
            if (bus_if.done || bus_if.busy) chk("midrst quiet", 64'({bus_if.done, bus_if.busy}), 64'd0);
            tick();
        end
        issue(F_MULTU, 32'd6, 32'd7);                    wait_done("multu 6*7");

        for (int i = 0; i < 8; i++) begin
            case ($urandom_range(3, 0))
                0:       fn = F_MULT;
                1:       fn = F_MULTU;
                2:       fn = F_DIV;
                default: fn = F_DIVU;
            endcase
            ra = $urandom();
            rb = ($urandom_range(3, 0) == 0) ? 32'($urandom_range(3, 0)) : $urandom();
            issue(fn, ra, rb);
            wait_done("random");
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
